// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter: FSM states,
// owner encoding and the default starvation limit.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   localparam int STARVE_MAX_DEFAULT = 4;

   // Counter is at least 3 bits and grows so that it can hold the limit itself.
   function automatic int starve_width(input int max_count);
      int w;
      w = 3;
      while ((1 << w) <= max_count) w++;
      return w;
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select and fetch-starvation counter; arbitration only happens while
// the parent FSM is idle (arb_en).
module mem_arb_prio
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic if_req,
   input  logic dm_req,
   output logic pick_valid,
   output logic pick_dm
);

   localparam int CW = starve_width(STARVE_MAX);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] count;
   logic          starved;

   assign starved = (count == CNT_MAX);

   always_comb begin
      pick_valid = if_req | dm_req;
      pick_dm    = dm_req & ~(if_req & starved);
   end

   // Only data wins taken over a waiting fetch count; anything else resets the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (arb_en) begin
         if (!if_req || !pick_dm) begin
            count <= '0;
         end else if (!starved) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction outstanding, with registered responses and stall outputs.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_wstrb,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem
);

   arb_state_t state;
   arb_owner_t owner;
   logic       drop;
   logic       pick_valid;
   logic       pick_dm;
   logic       flush_hit;

   mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clk        (clk),
      .rst        (rst),
      .arb_en     (state == ARB_IDLE),
      .if_req     (if_req),
      .dm_req     (dm_req),
      .pick_valid (pick_valid),
      .pick_dm    (pick_dm)
   );

   assign flush_hit = if_flush && (owner == OWN_IF) &&
                      ((state == ARB_ISSUE) || (state == ARB_WAIT));

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;

   // A flushed fetch still runs to completion on the bus; only its valid is hidden.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARB_IDLE;
         owner     <= OWN_IF;
         drop      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         if_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_rdata  <= '0;
         dm_valid  <= 1'b0;
      end else begin
         if (flush_hit) drop <= 1'b1;
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state   <= ARB_ISSUE;
                  mem_req <= 1'b1;
                  if (pick_dm) begin
                     owner     <= OWN_DM;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     mem_wstrb <= dm_wstrb;
                  end else begin
                     owner     <= OWN_IF;
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_wstrb <= '0;
                  end
               end
            end
            ARB_ISSUE: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (mem_rvalid) begin
                  state <= ARB_RESP;
                  if (owner == OWN_DM) begin
                     dm_rdata <= mem_rdata;
                     dm_valid <= 1'b1;
                  end else if (!(drop || flush_hit)) begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
                  end
               end
            end
            ARB_RESP: begin
               if_valid <= 1'b0;
               dm_valid <= 1'b0;
               drop     <= 1'b0;
               state    <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;

   logic        clk, rst;
   logic        if_req, if_flush, if_valid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_valid;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_wstrb;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        stall_if, stall_mem;

   int compared   = 0;
   int mismatched = 0;

   mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %08h, want %08h", name, actual, expected);
      end
   endtask

   // Memory contents: devMem is what the bus actually wrote, refMem what the
   // data port asked to be written.
   logic [31:0] devMem [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];

   function automatic logic [31:0] initWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
   endfunction

   function automatic logic [31:0] mergeWord(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function logic [31:0] devRead(input logic [31:0] a);
      return devMem.exists(a) ? devMem[a] : initWord(a);
   endfunction

   function logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : initWord(a);
   endfunction

   // Agent state
   logic        auto_mem = 1'b0, mem_rand = 1'b0, rand_req = 1'b0;
   logic        mem_busy = 1'b0;
   int          mem_delay = 0;
   logic [31:0] mem_hold = '0;
   logic        rv_prev = 1'b0, prev_mem_req = 1'b0, own_dm = 1'b0, exp_dm;
   int          starve_model = 0;
   logic        lq_if = 0, lq_dm = 0, lq_we = 0;
   logic [31:0] lq_if_addr = '0, lq_dm_addr = '0, lq_wdata = '0;
   logic [3:0]  lq_strb = '0;
   logic        grant_log[$];

   // Memory responder, random requesters and per-cycle model checks.
   always @(negedge clk) begin
      if (auto_mem && !rst) begin
         if (rand_req) begin
            checkOutput("stall_if", 32'(stall_if), 32'(if_req & ~if_valid));
            checkOutput("stall_mem", 32'(stall_mem), 32'(dm_req & ~dm_valid));
            checkOutput("if_valid_timing", 32'(if_valid), 32'(rv_prev & ~own_dm));
            checkOutput("dm_valid_timing", 32'(dm_valid), 32'(rv_prev & own_dm));
            if (if_valid) checkOutput("if_rdata", if_rdata, refRead(if_addr));
            if (dm_valid) begin
               if (dm_we) refMem[dm_addr] = mergeWord(refRead(dm_addr), dm_wdata, dm_wstrb);
               else checkOutput("dm_rdata", dm_rdata, refRead(dm_addr));
            end
         end
         if (mem_req && !prev_mem_req) begin
            exp_dm = lq_dm && !(lq_if && starve_model == SMAX);
            grant_log.push_back(mem_addr[28]);
            if (rand_req) begin
               checkOutput("arb_addr", mem_addr, exp_dm ? lq_dm_addr : lq_if_addr);
               checkOutput("arb_we", 32'(mem_we), exp_dm ? 32'(lq_we) : 32'd0);
               checkOutput("arb_wdata", mem_wdata, exp_dm ? lq_wdata : 32'd0);
               checkOutput("arb_wstrb", 32'(mem_wstrb), exp_dm ? 32'(lq_strb) : 32'd0);
            end
            if (!lq_if || !exp_dm) starve_model = 0;
            else if (starve_model < SMAX) starve_model++;
            own_dm = exp_dm;
         end
         if (rand_req) begin
            if (if_valid) if_req = 1'($urandom_range(0, 1));
            else if (!if_req) if_req = ($urandom_range(0, 3) == 0);
            if (if_valid || !lq_if) if_addr = {22'h0, 8'($urandom), 2'b00};
            if (dm_valid) dm_req = 1'($urandom_range(0, 1));
            else if (!dm_req) dm_req = ($urandom_range(0, 2) == 0);
            if (dm_valid || !lq_dm) begin
               dm_addr  = 32'h1000_0000 | {27'h0, 3'($urandom), 2'b00};
               dm_we    = 1'($urandom);
               dm_wdata = $urandom;
               dm_wstrb = 4'($urandom);
            end
            lq_if = if_req; lq_if_addr = if_addr;
            lq_dm = dm_req; lq_dm_addr = dm_addr;
            lq_we = dm_we;  lq_wdata = dm_wdata; lq_strb = dm_wstrb;
         end
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (mem_busy) begin
            if (mem_delay == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_hold;
               mem_busy   = 1'b0;
            end else begin
               mem_delay--;
            end
         end else if (mem_req) begin
            if (!mem_rand || $urandom_range(0, 2) != 0) begin
               mem_gnt   = 1'b1;
               mem_busy  = 1'b1;
               mem_delay = mem_rand ? int'($urandom_range(0, 2)) : 0;
               if (mem_we) devMem[mem_addr] = mergeWord(devRead(mem_addr), mem_wdata, mem_wstrb);
               mem_hold = devRead(mem_addr);
            end
         end
         rv_prev      = mem_rvalid;
         prev_mem_req = mem_req;
      end
   end

   task automatic applyReset();
      rst = 1'b1;
      auto_mem = 1'b0; rand_req = 1'b0; mem_rand = 1'b0; mem_busy = 1'b0;
      rv_prev = 1'b0; prev_mem_req = 1'b0; own_dm = 1'b0; starve_model = 0;
      lq_if = 0; lq_dm = 0;
      if_req = 0; if_addr = '0; if_flush = 0;
      dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        if_req;  logic [31:0] if_addr;
      logic        dm_req;  logic        dm_we;   logic [31:0] dm_addr;
      logic [31:0] dm_wdata; logic [3:0] dm_wstrb;
      logic        gnt;     logic        rvalid;  logic [31:0] rdata;
      logic        e_req;   logic        e_we;    logic [31:0] e_addr;
      logic [31:0] e_wdata; logic [3:0]  e_strb;
      logic        e_ifv;   logic [31:0] e_ifd;   logic        e_dmv;
      logic        e_sif;   logic        e_smem;
   } vec_t;

   vec_t vecs[12];

   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clk);
      if_req = v.if_req; if_addr = v.if_addr;
      dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr;
      dm_wdata = v.dm_wdata; dm_wstrb = v.dm_wstrb;
      mem_gnt = v.gnt; mem_rvalid = v.rvalid; mem_rdata = v.rdata;
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'(v.e_req));
      if (v.e_req) begin
         checkOutput($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.e_we));
         checkOutput($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
         checkOutput($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
         checkOutput($sformatf("v%0d mem_wstrb", idx), 32'(mem_wstrb), 32'(v.e_strb));
      end
      checkOutput($sformatf("v%0d if_valid", idx), 32'(if_valid), 32'(v.e_ifv));
      if (v.e_ifv) checkOutput($sformatf("v%0d if_rdata", idx), if_rdata, v.e_ifd);
      checkOutput($sformatf("v%0d dm_valid", idx), 32'(dm_valid), 32'(v.e_dmv));
      checkOutput($sformatf("v%0d stall_if", idx), 32'(stall_if), 32'(v.e_sif));
      checkOutput($sformatf("v%0d stall_mem", idx), 32'(stall_mem), 32'(v.e_smem));
   endtask

   initial begin
      // Lone fetch at 0x40, then simultaneous fetch 0x44 and store 0x100.
      vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h00500093,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,
                   1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

      applyReset();
      rst = 1'b1;
      #1;
      checkOutput("rst mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst mem_addr", mem_addr, 32'd0);
      checkOutput("rst mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
      checkOutput("rst if_valid", 32'(if_valid), 32'd0);
      checkOutput("rst dm_valid", 32'(dm_valid), 32'd0);
      checkOutput("rst if_rdata", if_rdata, 32'd0);
      checkOutput("rst dm_rdata", dm_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

      // Starvation: both ports held; expect DDDD I DDDD I
      applyReset();
      grant_log.delete();
      if_req = 1'b1; if_addr = 32'h80;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0000;
      @(posedge clk);
      auto_mem = 1'b1;
      for (int c = 0; c < 300 && grant_log.size() < 10; c++) @(posedge clk);
      if (grant_log.size() < 10) begin
         compared++; mismatched++;
         $display("[TB] FAIL starve_timeout: got %0d grants, want 10", grant_log.size());
      end else begin
         for (int i = 0; i < 10; i++)
            checkOutput($sformatf("starve grant%0d owner_dm", i), 32'(grant_log[i]),
                        (i % 5 == 4) ? 32'd0 : 32'd1);
      end
      auto_mem = 1'b0;

      // Flush in WAIT: result dropped, refetch at new address completes.
      applyReset();
      @(negedge clk); if_req = 1'b1; if_addr = 32'h40;
      @(posedge clk); #1; checkOutput("flush issue mem_req", 32'(mem_req), 32'd1);
      @(negedge clk); mem_gnt = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); mem_gnt = 1'b0; if_flush = 1'b1; if_addr = 32'h48;
      @(posedge clk); #1;
      @(negedge clk); if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
      @(posedge clk); #1; checkOutput("flush if_valid resp", 32'(if_valid), 32'd0);
      @(negedge clk); mem_rvalid = 1'b0;
      @(posedge clk); #1; checkOutput("flush if_valid idle", 32'(if_valid), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      checkOutput("refetch mem_req", 32'(mem_req), 32'd1);
      checkOutput("refetch mem_addr", mem_addr, 32'h48);
      @(negedge clk); mem_gnt = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00600113;
      @(posedge clk); #1;
      checkOutput("refetch if_valid", 32'(if_valid), 32'd1);
      checkOutput("refetch if_rdata", if_rdata, 32'h00600113);
      @(negedge clk); mem_rvalid = 1'b0; if_req = 1'b0;

      // Grant withheld for 5 cycles on a byte store.
      applyReset();
      @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h104;
      dm_wdata = 32'hCAFEF00D; dm_wstrb = 4'h2;
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("hold%0d mem_req", k), 32'(mem_req), 32'd1);
         checkOutput($sformatf("hold%0d mem_addr", k), mem_addr, 32'h104);
         checkOutput($sformatf("hold%0d mem_wdata", k), mem_wdata, 32'hCAFEF00D);
         checkOutput($sformatf("hold%0d mem_wstrb", k), 32'(mem_wstrb), 32'h2);
         if (k < 5) begin
            @(negedge clk); mem_gnt = 1'b0;
            @(posedge clk); #1;
         end
      end
      @(negedge clk); mem_gnt = 1'b1;
      @(posedge clk); #1; checkOutput("hold wait mem_req", 32'(mem_req), 32'd0);
      @(negedge clk); mem_gnt = 1'b0;
      @(posedge clk); #1;
      checkOutput("hold no dup mem_req", 32'(mem_req), 32'd0);
      checkOutput("hold early dm_valid", 32'(dm_valid), 32'd0);
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h0;
      @(posedge clk); #1;
      checkOutput("hold dm_valid", 32'(dm_valid), 32'd1);
      checkOutput("hold stall_mem", 32'(stall_mem), 32'd0);
      @(negedge clk); mem_rvalid = 1'b0; dm_req = 1'b0;
      @(posedge clk); #1; checkOutput("hold dm_valid pulse", 32'(dm_valid), 32'd0);

      // Reset mid-transaction: ISSUE (async drop), then WAIT with late response.
      applyReset();
      @(negedge clk); if_req = 1'b1; if_addr = 32'h50;
      @(posedge clk); #1; checkOutput("rst issue mem_req", 32'(mem_req), 32'd1);
      @(negedge clk); rst = 1'b1;
      #1; checkOutput("rst async mem_req", 32'(mem_req), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); mem_gnt = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); mem_gnt = 1'b0; rst = 1'b1;
      #1;
      checkOutput("rst wait mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst wait if_valid", 32'(if_valid), 32'd0);
      checkOutput("rst wait dm_valid", 32'(dm_valid), 32'd0);
      @(negedge clk); rst = 1'b0; if_req = 1'b0;
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("late rvalid if_valid%0d", k), 32'(if_valid), 32'd0);
         checkOutput($sformatf("late rvalid mem_req%0d", k), 32'(mem_req), 32'd0);
         @(negedge clk); mem_rvalid = 1'b0;
      end

      // Randomized traffic against the model.
      applyReset();
      devMem.delete();
      refMem.delete();
      @(posedge clk);
      mem_rand = 1'b1; auto_mem = 1'b1; rand_req = 1'b1;
      repeat (4000) @(posedge clk);
      rand_req = 1'b0; auto_mem = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
